bcd_seq_adder: RTL and testbench

- Sequential packed-BCD adder; the add-direction counterpart of the team's structural BCD subtractor.
- Adds two WIDTH-bit packed-BCD operands, one decimal digit per clock, using a single 4-bit digit adder with decimal correction. This trades latency for area.
- Sits in the ALU datapath beside the subtractor and uses a start/busy/done handshake.

---
 rtl/bcd_seq_adder_if.sv | 30 +++
 rtl/bcd_seq_adder.sv | 159 +++++++++++++++
 tb/tb_bcd_seq_adder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_seq_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_seq_adder_if
//  Brief    : start/busy/done handshake and operand/result bus of bcd_seq_adder
//  Revision : 1.0 - initial release
// ============================================================================
interface bcd_seq_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, x, y, cin,
        input  sum, cout, busy, done, err
    );

    modport slave (
        input  start, x, y, cin,
        output sum, cout, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_seq_adder
//  Brief    : packed-BCD adder, one decimal digit per clock through a single
//             corrected 4-bit digit adder. Optional BCD_DIGIT_CHECK_EN adds
//             the invalid-digit (err) flag.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_seq_adder #(
    parameter int WIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    bcd_seq_adder_if.slave     bus
);
    localparam int DIGITS = WIDTH / 4;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xw_q, xw_d;
    logic [WIDTH-1:0] yw_q, yw_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [4:0]       w_t;
    logic [4:0]       w_t_adj;
    logic             w_dcarry;
    logic [3:0]       w_digit;
    logic [WIDTH-1:0] w_res_next;

    // Single digit adder: binary sum then +6 correction when above 9.
    always_comb begin
        w_t        = {1'b0, xw_q[3:0]} + {1'b0, yw_q[3:0]} + {4'b0000, c_q};
        w_t_adj    = w_t + 5'd6;
        w_dcarry   = (w_t > 5'd9);
        w_digit    = w_dcarry ? w_t_adj[3:0] : w_t[3:0];
        w_res_next = res_q >> 4;
        w_res_next[WIDTH-1 -: 4] = w_digit;
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic              err_q, err_d;
    logic [DIGITS-1:0] w_nib_bad;
    logic              w_bad;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib_chk
        assign w_nib_bad[gi] = (bus.x[4*gi +: 4] > 4'd9) | (bus.y[4*gi +: 4] > 4'd9);
    end

    assign w_bad   = |w_nib_bad;
    assign bus.err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && bus.start) begin
            err_d = w_bad;
        end
    end
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            xw_q    <= '0;
            yw_q    <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xw_q    <= xw_d;
            yw_q    <= yw_d;
            res_q   <= res_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        xw_d    = xw_q;
        yw_d    = yw_q;
        res_d   = res_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    xw_d    = bus.x;
                    yw_d    = bus.y;
                    c_d     = bus.cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                xw_d  = xw_q >> 4;
                yw_d  = yw_q >> 4;
                c_d   = w_dcarry;
                res_d = w_res_next;
                cnt_d = cnt_q + CNT_W'(1);
                // Results are published only here, so sum/cout stay stable while busy.
                if (cnt_q == LAST_CNT) begin
                    sum_d   = w_res_next;
                    cout_d  = w_dcarry;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_seq_adder
//  Brief    : randomized bench for bcd_seq_adder against a decimal reference
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_seq_adder;
    localparam int WIDTH  = 32;
    localparam int DIGITS = WIDTH / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_seq_adder_if #(.WIDTH(WIDTH)) bus ();

    bcd_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_sum  = '0;
    logic        exp_cout = 1'b0;
    logic        exp_err  = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic bit is_bcd(input logic [31:0] v);
        bit ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic longint bcd2int(input logic [31:0] v);
        longint n = 0;
        for (int i = DIGITS - 1; i >= 0; i--) n = n * 10 + longint'(v[4*i +: 4]);
        return n;
    endfunction

    function automatic logic [31:0] int2bcd(input longint n);
        logic [31:0] v = '0;
        longint      r = n;
        for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return v;
    endfunction

    function automatic logic [31:0] rand_bcd();
        logic [31:0] v = '0;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Valid operands: decimal arithmetic. Invalid digits: the per-digit rule.
    function automatic void ref_add(input logic [31:0] a, input logic [31:0] b, input logic ci,
                                    output logic [31:0] s, output logic co);
        longint n;
        int     c;
        int     t;
        s = '0;
        co = 1'b0;
        if (is_bcd(a) && is_bcd(b)) begin
            n  = bcd2int(a) + bcd2int(b) + longint'(ci);
            co = (n >= 64'd100000000);
            s  = int2bcd(n % 100000000);
        end else begin
            c = int'(ci);
            for (int i = 0; i < DIGITS; i++) begin
                t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
                if (t > 9) begin
                    s[4*i +: 4] = 4'((t + 6) % 16);
                    c = 1;
                end else begin
                    s[4*i +: 4] = 4'(t);
                    c = 0;
                end
            end
            co = (c != 0);
        end
    endfunction

    function automatic logic exp_err_of(input logic [31:0] a, input logic [31:0] b);
`ifdef BCD_DIGIT_CHECK_EN
        return !(is_bcd(a) && is_bcd(b));
`else
        return 1'b0 & a[0] & b[0];
`endif
    endfunction

    // Waits for done; every non-done cycle must show busy and the old result.
    task automatic wait_done(input string tag, output int edges, output bit got);
        int unstable = 0;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 4 * DIGITS) begin
            @(posedge clk); #1;
            edges++;
            if (bus.done) got = 1'b1;
            else if (bus.sum !== exp_sum || bus.cout !== exp_cout || bus.busy !== 1'b1) unstable++;
        end
        check({tag, "_stable"}, 64'(unstable), 64'd0);
        check({tag, "_done_seen"}, 64'(got), 64'd1);
    endtask

    task automatic finish_result(input string tag, input logic [31:0] a, input logic [31:0] b, input logic ci);
        logic [31:0] s;
        logic        co;
        ref_add(a, b, ci, s, co);
        exp_sum  = s;
        exp_cout = co;
        exp_err  = exp_err_of(a, b);
        check({tag, "_sum"},  64'(bus.sum),  64'(exp_sum));
        check({tag, "_cout"}, 64'(bus.cout), 64'(exp_cout));
        check({tag, "_err"},  64'(bus.err),  64'(exp_err));
        check({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic ci);
        int edges;
        bit got;
        @(negedge clk);
        bus.x = a; bus.y = b; bus.cin = ci; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.x = $urandom; bus.y = $urandom; bus.cin = 1'($urandom);
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        wait_done(tag, edges, got);
        check({tag, "_latency"}, 64'(edges), 64'(DIGITS));
        finish_result(tag, a, b, ci);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          edges;
        bit          got;
        int          extra;
        logic [31:0] a, b;
        logic        ci;

        bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sum",  64'(bus.sum),  64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_err",  64'(bus.err),  64'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("basic",   32'h0000_0045, 32'h0000_0038, 1'b0);
        run_op("chain",   32'h9999_9999, 32'h0000_0001, 1'b0);
        run_op("all9s",   32'h9999_9999, 32'h9999_9999, 1'b1);
        run_op("cinonly", 32'h0000_0000, 32'h0000_0000, 1'b1);

        // Back-to-back: start held high through the first done.
        @(negedge clk);
        bus.x = 32'h0000_1234; bus.y = 32'h0000_5678; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.x = 32'h5000_0000; bus.y = 32'h5000_0000; bus.cin = 1'b1;
        wait_done("b2b_a", edges, got);
        check("b2b_a_latency", 64'(edges), 64'(DIGITS));
        finish_result("b2b_a", 32'h0000_1234, 32'h0000_5678, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_accept", 64'(bus.busy), 64'd1);
        wait_done("b2b_b", edges, got);
        check("b2b_b_latency", 64'(edges), 64'(DIGITS));
        finish_result("b2b_b", 32'h5000_0000, 32'h5000_0000, 1'b1);

        // Start pulse during busy at E3 must be ignored.
        @(negedge clk);
        bus.x = 32'h0000_0012; bus.y = 32'h0000_0034; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus.x = 32'h9999_9999; bus.y = 32'h0000_0001; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("busy_start", edges, got);
        check("busy_start_latency", 64'(edges), 64'(DIGITS - 3));
        finish_result("busy_start", 32'h0000_0012, 32'h0000_0034, 1'b0);
        extra = 0;
        repeat (2 * DIGITS) begin @(posedge clk); #1; if (bus.done) extra++; end
        check("busy_start_no_done", 64'(extra), 64'd0);

        // Reset between E4 and E5.
        @(negedge clk);
        bus.x = 32'h1111_1111; bus.y = 32'h2222_2222; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #1 rst_n = 1'b0;
        #1;
        check("midrst_sum",  64'(bus.sum),  64'd0);
        check("midrst_cout", 64'(bus.cout), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        exp_sum = '0; exp_cout = 1'b0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        extra = 0;
        repeat (2 * DIGITS) begin @(posedge clk); #1; if (bus.done) extra++; end
        check("midrst_no_done", 64'(extra), 64'd0);
        run_op("postrst", 32'h0000_0777, 32'h0000_0333, 1'b0);

        run_op("digchk_bad",  32'h0000_000A, 32'h0000_0000, 1'b0);
        run_op("digchk_good", 32'h0000_0001, 32'h0000_0002, 1'b0);

        for (int i = 0; i < 30; i++) begin
            a  = rand_bcd();
            b  = rand_bcd();
            ci = 1'($urandom);
            run_op("rand_bcd", a, b, ci);
        end
        for (int i = 0; i < 6; i++) begin
            a  = $urandom;
            b  = $urandom;
            ci = 1'($urandom);
            run_op("rand_raw", a, b, ci);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
